// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants and helpers for the MDIO master.
//   - ST/OP codes as transmitted on the wire
//   - FSM state encodings and per-state bit counts
//   - frame_word(): packs ST..DATA (32 bits) of a frame, MSB first
package mdio_pkg;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] C22_WR    = 2'b01;
  localparam logic [1:0] C22_RD    = 2'b10;
  localparam logic [1:0] C45_ADDR  = 2'b00;
  localparam logic [1:0] C45_WR    = 2'b01;
  localparam logic [1:0] C45_RD    = 2'b11;
  localparam logic [1:0] C45_RDINC = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

  // Read-type frames release the bus at TA; everything else is a write-type frame.
  function automatic logic op_is_read(input logic c45, input logic [1:0] op);
    logic rd;
    rd = 1'b0;
    if (c45) begin
      case (op)
        C45_ADDR, C45_WR:  rd = 1'b0;
        C45_RD, C45_RDINC: rd = 1'b1;
        default:           rd = 1'b0;
      endcase
    end else begin
      rd = (op == C22_RD);
    end
    return rd;
  endfunction

  // For reads the TA/DATA part is filled with ones so the idle drive value stays high.
  function automatic logic [31:0] frame_word(input logic c45, input logic [1:0] op,
                                             input logic [4:0] phyad, input logic [4:0] regad,
                                             input logic rd, input logic [15:0] wdata);
    logic [1:0] st;
    st = c45 ? ST_C45 : ST_C22;
    if (rd) begin
      return {st, op, phyad, regad, 2'b11, 16'hFFFF};
    end else begin
      return {st, op, phyad, regad, 2'b10, wdata};
    end
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC generator for the MDIO master.
//   i_clk, i_reset : system clock, async active-high reset
//   enable         : high while a frame is in progress; low holds MDC low and the divider cleared
//   o_mdc          : management clock, low half first in every bit time
//   rise_tick      : high on the cycle whose edge drives MDC high
//   fall_tick      : high on the cycle whose edge drives MDC low (next bit starts)
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic enable,
  output logic o_mdc,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             half_end;

  assign half_end  = enable && (div_cnt == DIV_LAST);
  assign rise_tick = half_end && !o_mdc;
  assign fall_tick = half_end && o_mdc;

  // Divider counts 0..CLK_DIV-1 per MDC half-period and toggles MDC at the end of each half.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_cnt <= '0;
      o_mdc   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      o_mdc   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      o_mdc   <= !o_mdc;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: Clause 22 / Clause 45 MDIO master with its own MDC.
//   Host:  i_cmd_valid/o_cmd_ready handshake with i_clause45, i_op, i_phy_addr,
//          i_reg_addr, i_wdata; o_rsp_valid strobe with o_rdata and o_rsp_err.
//   Bus:   o_mdc, o_mdio_out, o_mdio_oe, i_mdio_in (tri-state lives in the pad wrapper).
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_EN       = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_clause45,
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [15:0] o_rdata,
  output logic        o_rsp_err,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_TA   = 2'd1;
  localparam logic [1:0] TAG_DATA = 2'd2;

  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic        is_read;
  logic [15:0] rd_sr;
  logic        ta_err;
  logic        sync1, sync2;
  logic [1:0]  tag, tag_d1, tag_d2;
  logic        busy, fall_tick, rise_tick, accept;
  logic        illegal, req_read;
  logic [31:0] req_word;

  assign busy   = (state != S_IDLE);
  assign accept = i_cmd_valid && o_cmd_ready;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .enable    (busy),
    .o_mdc     (o_mdc),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  // Decode the incoming command: legality, direction and the packed wire word.
  always_comb begin
    illegal  = 1'b0;
    req_read = 1'b0;
    if (i_clause45) begin
      illegal  = (C45_EN == 0);
      req_read = op_is_read(1'b1, i_op);
    end else begin
      illegal  = (i_op != C22_WR) && (i_op != C22_RD);
      req_read = op_is_read(1'b0, i_op);
    end
    req_word = frame_word(i_clause45, i_op, i_phy_addr, i_reg_addr, req_read, i_wdata);
  end

  // Two-flop synchroniser on the pad input; idle bus is pulled high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_mdio_in;
      sync2 <= sync1;
    end
  end

  // Mark the MDC rises that must be sampled: second TA bit and every DATA bit of a read.
  always_comb begin
    tag = TAG_NONE;
    if (rise_tick && is_read) begin
      case (state)
        S_TA:    tag = (bit_cnt == TA_LAST) ? TAG_TA : TAG_NONE;
        S_DATA:  tag = TAG_DATA;
        default: tag = TAG_NONE;
      endcase
    end else begin
      tag = TAG_NONE;
    end
  end

  // Delay the sample tag by the synchroniser depth so it lines up with the bit seen at the rise.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_d1 <= TAG_NONE;
      tag_d2 <= TAG_NONE;
      ta_err <= 1'b0;
      rd_sr  <= '0;
    end else begin
      tag_d1 <= tag;
      tag_d2 <= tag_d1;
      if (accept) begin
        ta_err <= 1'b0;
        rd_sr  <= '0;
      end else if (tag_d2 == TAG_TA) begin
        ta_err <= sync2;
      end else if (tag_d2 == TAG_DATA) begin
        rd_sr <= {rd_sr[14:0], sync2};
      end
    end
  end

  // Frame sequencer: every bit change happens on the edge where MDC falls.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      is_read     <= 1'b0;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rdata     <= '0;
      o_rsp_err   <= 1'b0;
      o_mdio_out  <= 1'b1;
      o_mdio_oe   <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && illegal) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rdata     <= '0;
          end else if (accept) begin
            o_cmd_ready <= 1'b0;
            is_read     <= req_read;
            o_mdio_oe   <= 1'b1;
            bit_cnt     <= '0;
            if (PREAMBLE_LEN == 0) begin
              state      <= S_HDR;
              o_mdio_out <= req_word[31];
              tx_sr      <= {req_word[30:0], 1'b1};
            end else begin
              state      <= S_PRE;
              o_mdio_out <= 1'b1;
              tx_sr      <= req_word;
            end
          end
        end
        S_PRE: if (fall_tick) begin
          if (bit_cnt == PRE_LAST) begin
            state      <= S_HDR;
            bit_cnt    <= '0;
            o_mdio_out <= tx_sr[31];
            tx_sr      <= {tx_sr[30:0], 1'b1};
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_HDR: if (fall_tick) begin
          o_mdio_out <= tx_sr[31];
          tx_sr      <= {tx_sr[30:0], 1'b1};
          if (bit_cnt == HDR_LAST) begin
            state     <= S_TA;
            bit_cnt   <= '0;
            o_mdio_oe <= !is_read;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_TA: if (fall_tick) begin
          o_mdio_out <= tx_sr[31];
          tx_sr      <= {tx_sr[30:0], 1'b1};
          if (bit_cnt == TA_LAST) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        S_DATA: if (fall_tick) begin
          if (bit_cnt == DATA_LAST) begin
            state      <= S_GAP;
            bit_cnt    <= '0;
            o_mdio_oe  <= 1'b0;
            o_mdio_out <= 1'b1;
          end else begin
            o_mdio_out <= tx_sr[31];
            tx_sr      <= {tx_sr[30:0], 1'b1};
            bit_cnt    <= bit_cnt + 6'd1;
          end
        end
        S_GAP: if (fall_tick) begin
          state       <= S_IDLE;
          o_cmd_ready <= 1'b1;
          o_rsp_valid <= 1'b1;
          if (is_read) begin
            o_rsp_err <= ta_err;
            o_rdata   <= ta_err ? 16'hFFFF : rd_sr;
          end else begin
            o_rsp_err <= 1'b0;
            o_rdata   <= '0;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_cmd_ready <= 1'b1;
          o_mdio_oe   <= 1'b0;
          o_mdio_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb_mdio_master_ctrl: scoreboard bench for mdio_master_ctrl.
// The driver pushes hand-computed expectations on acceptance; the monitor pops and
// compares on every o_rsp_valid, including the bits captured on the wire at MDC rises.
module tb_mdio_master_ctrl;

  localparam int D     = 2;
  localparam int P     = 32;
  localparam int N_LAT = 2 * D * (P + 33) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, ready, clause45, rsp_valid, rsp_err, mdc, mdio_out, mdio_oe, mdio_in;
  logic [1:0]  op;
  logic [4:0]  phy, rg;
  logic [15:0] wdata, rdata;

  logic        rst0, valid0, ready0, rsp_valid0, rsp_err0, mdc0, mdio_out0, mdio_oe0, mdio_in0;
  logic [15:0] rdata0;

  mdio_master_ctrl #(.CLK_DIV(D), .PREAMBLE_LEN(P), .C45_EN(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
    .i_clause45(clause45), .i_op(op), .i_phy_addr(phy), .i_reg_addr(rg), .i_wdata(wdata),
    .o_rsp_valid(rsp_valid), .o_rdata(rdata), .o_rsp_err(rsp_err), .o_mdc(mdc),
    .o_mdio_out(mdio_out), .o_mdio_oe(mdio_oe), .i_mdio_in(mdio_in)
  );

  mdio_master_ctrl #(.CLK_DIV(D), .PREAMBLE_LEN(0), .C45_EN(1)) dut0 (
    .i_clk(clk), .i_reset(rst0), .i_cmd_valid(valid0), .o_cmd_ready(ready0),
    .i_clause45(clause45), .i_op(op), .i_phy_addr(phy), .i_reg_addr(rg), .i_wdata(wdata),
    .o_rsp_valid(rsp_valid0), .o_rdata(rdata0), .o_rsp_err(rsp_err0), .o_mdc(mdc0),
    .o_mdio_out(mdio_out0), .o_mdio_oe(mdio_oe0), .i_mdio_in(mdio_in0)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    logic        is_frame;
    logic        is_read;
    logic [13:0] hdr;
    logic [17:0] tadata;
    logic [15:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sbq[$];
  int   rsp_hist[$];

  // Wire capture and PHY bus model.
  logic [127:0] cap_out = '0, cap_oe = '0, cap0_out = '0, cap0_oe = '0;
  int cap_n = 0, cap0_n = 0, fall_cnt = 0, cap_base = 0, fall_base = 0, rsp0_cnt = 0;
  logic        phy_present = 1'b0, cur_read = 1'b0, phy_drv;
  logic [15:0] phy_data = '0;
  int          bi;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge mdc) begin
    cap_out <= {cap_out[126:0], mdio_out};
    cap_oe  <= {cap_oe[126:0], mdio_oe};
    cap_n   <= cap_n + 1;
  end
  always @(negedge mdc) fall_cnt <= fall_cnt + 1;
  always @(posedge mdc0) begin
    cap0_out <= {cap0_out[126:0], mdio_out0};
    cap0_oe  <= {cap0_oe[126:0], mdio_oe0};
    cap0_n   <= cap0_n + 1;
  end
  always @(posedge clk) if (rsp_valid0) rsp0_cnt <= rsp0_cnt + 1;

  // PHY answers a read: TA second bit low, then 16 data bits, each set up after MDC falls.
  always_comb begin
    bi      = fall_cnt - fall_base;
    phy_drv = 1'b1;
    if (phy_present && cur_read) begin
      if (bi == P + 15) phy_drv = 1'b0;
      else if (bi >= P + 16 && bi <= P + 31) phy_drv = phy_data[P + 31 - bi];
    end
  end
  assign mdio_in  = mdio_oe ? mdio_out : phy_drv;
  assign mdio_in0 = mdio_oe0 ? mdio_out0 : 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pop one expectation per response strobe and compare.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 128'd1, 128'd0);
      end else begin
        exp_t e;
        int   lat, fn;
        logic [127:0] fmask;
        e     = sbq.pop_front();
        lat   = cyc + 1 - e.acc;
        fn    = cap_n - cap_base;
        fmask = (128'd1 << (P + 33)) - 128'd1;
        chk("rdata", rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("latency", lat, e.is_frame ? N_LAT : 1);
        chk("bit_count", fn, e.is_frame ? P + 33 : 0);
        if (e.is_frame) begin
          chk("preamble", (cap_out >> 33) & ((128'd1 << P) - 128'd1), (128'd1 << P) - 128'd1);
          chk("header", cap_out[32:19], e.hdr);
          chk("oe_pattern", cap_oe & fmask,
              e.is_read ? (((128'd1 << (P + 14)) - 128'd1) << 19)
                        : (((128'd1 << (P + 32)) - 128'd1) << 1));
          if (!e.is_read) chk("ta_data", cap_out[18:1], e.tadata);
        end
      end
      rsp_hist.push_back(cyc + 1);
      cap_base  = cap_n;
      fall_base = fall_cnt;
    end
  end

  task automatic issue(input logic c45, input logic [1:0] o, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic is_frame, input logic rd,
                       input logic [13:0] hdr, input logic [17:0] tad, input logic [15:0] erd,
                       input logic eerr, output int acc);
    int   w;
    exp_t e;
    @(negedge clk);
    clause45 = c45; op = o; phy = pa; rg = ra; wdata = wd; valid = 1'b1;
    w = 0;
    while (!ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    acc = -1;
    if (!ready) begin
      chk("accept_timeout", 128'd0, 128'd1);
    end else begin
      acc = cyc + 1;
      cur_read = rd;
      e = '{is_frame, rd, hdr, tad, erd, eerr, acc};
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 valid = 1'b0;
    clause45 = 1'b0; op = 2'b00; phy = '0; rg = '0; wdata = '0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    if (sbq.size() != 0) chk("rsp_timeout", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, w, base;
    rst = 1'b1; rst0 = 1'b1; valid = 1'b0; valid0 = 1'b0;
    clause45 = 1'b0; op = 2'b00; phy = '0; rg = '0; wdata = '0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_mdc", mdc, 1'b0);
    chk("rst_oe", mdio_oe, 1'b0);
    chk("rst_out", mdio_out, 1'b1);
    @(negedge clk);
    rst = 1'b0; rst0 = 1'b0;
    cap_base = cap_n; fall_base = fall_cnt;

    // C22 write phy=3 reg=2 data=BEEF.
    issue(1'b0, 2'b01, 5'd3, 5'd2, 16'hBEEF, 1'b1, 1'b0, 14'b01_01_00011_00010,
          18'b10_1011_1110_1110_1111, 16'h0000, 1'b0, a1);
    #20 chk("busy_ready", ready, 1'b0);
    wait_idle();

    // C22 read phy=1 reg=1 answered with 796D.
    phy_present = 1'b1; phy_data = 16'h796D;
    issue(1'b0, 2'b10, 5'd1, 5'd1, 16'h1234, 1'b1, 1'b1, 14'b01_10_00001_00001,
          18'h0, 16'h796D, 1'b0, a1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("hold_rdata", rdata, 16'h796D);

    // C22 read with no PHY: line stays high.
    phy_present = 1'b0;
    issue(1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 1'b1, 1'b1, 14'b01_10_00001_00001,
          18'h0, 16'hFFFF, 1'b1, a1);
    wait_idle();

    // C45 address frame then read, back-to-back.
    phy_present = 1'b1; phy_data = 16'hA5C3;
    issue(1'b1, 2'b00, 5'd1, 5'd1, 16'h0007, 1'b1, 1'b0, 14'b00_00_00001_00001,
          18'b10_0000_0000_0000_0111, 16'h0000, 1'b0, a1);
    issue(1'b1, 2'b11, 5'd1, 5'd1, 16'h0000, 1'b1, 1'b1, 14'b00_11_00001_00001,
          18'h0, 16'hA5C3, 1'b0, a2);
    wait_idle();
    chk("b2b_accept", a2, (rsp_hist.size() >= 2) ? rsp_hist[rsp_hist.size() - 2] : -1);

    // Illegal C22 ops: immediate error response, no bus activity.
    issue(1'b0, 2'b00, 5'd1, 5'd1, 16'h0000, 1'b0, 1'b0, 14'h0, 18'h0, 16'h0000, 1'b1, a1);
    wait_idle();
    issue(1'b0, 2'b11, 5'd2, 5'd4, 16'h0000, 1'b0, 1'b0, 14'h0, 18'h0, 16'h0000, 1'b1, a1);
    wait_idle();

    // No-preamble instance: frame begins with ST, then reset mid-DATA aborts it.
    @(negedge clk);
    clause45 = 1'b0; op = 2'b01; phy = 5'd3; rg = 5'd2; wdata = 16'hBEEF; valid0 = 1'b1;
    @(posedge clk);
    #1 valid0 = 1'b0;
    w = 0;
    while (cap0_n < 2 && w < 100) begin @(negedge clk); w++; end
    chk("st_no_pre", cap0_out[1:0], 2'b01);
    chk("st_no_pre_oe", cap0_oe[1:0], 2'b11);
    w = 0;
    while (cap0_n < 20 && w < 200) begin @(negedge clk); w++; end
    chk("pre0_in_data", 128'(cap0_n >= 20), 128'd1);
    @(posedge clk);
    #2 rst0 = 1'b1;
    #1;
    chk("abort_mdc", mdc0, 1'b0);
    chk("abort_oe", mdio_oe0, 1'b0);
    chk("abort_out", mdio_out0, 1'b1);
    chk("abort_ready", ready0, 1'b1);
    chk("abort_rsp", rsp_valid0, 1'b0);
    @(negedge clk);
    rst0 = 1'b0;
    base = cap0_n;
    repeat (200) @(negedge clk);
    chk("abort_no_rsp", rsp0_cnt, 0);
    chk("abort_mdc_idle", cap0_n - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
